// File: rtl/riscv_icache_biu_fill_if.sv
// Bus-side types and interface for the instruction-cache BIU fill unit.
// Package: command/size/burst-type encodings shared by the fill unit and the BIU.
// Interface: request/response handshake between the fill unit (master) and the BIU (slave).
//   stb/stb_ack : request strobe and acceptance
//   adri/size/btype/we : request attributes
//   q/ack/err   : response data, beat valid, beat error

package riscv_icache_biu_fill_pkg;
    typedef enum logic [1:0] {
        BIUCMD_NOP      = 2'd0,
        BIUCMD_READWAY  = 2'd1,
        BIUCMD_WRITEWAY = 2'd2
    } biucmd_t;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } biu_type_t;
endpackage

interface riscv_icache_biu_fill_if
    import riscv_icache_biu_fill_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PLEN = 34
) ();
    logic            stb;
    logic            stb_ack;
    logic [PLEN-1:0] adri;
    biu_size_t       size;
    biu_type_t       btype;
    logic            we;
    logic [XLEN-1:0] q;
    logic            ack;
    logic            err;

    modport master (output stb, adri, size, btype, we, input stb_ack, q, ack, err);
    modport slave  (input stb, adri, size, btype, we, output stb_ack, q, ack, err);
endinterface

// File: rtl/riscv_icache_biu_fill.sv
// BIU-side responder for the instruction-cache FSM.
// Services READWAY line fills as critical-word-first wrap bursts and single
// non-cacheable (NC) fetches, forwards every beat to the cache FSM with zero
// latency and assembles filled lines in a local buffer.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   flush_i                       pipe flush; drop responses of outstanding NC reads
//   biucmd_i / biucmd_ack_o       line fill command / line complete pulse
//   biucmd_noncacheable_req_i/_ack_o  NC fetch request / NC data valid
//   biucmd_adri_i                 request address; adr_i: fetch address for buffer lookup
//   inflight_cnt_o                outstanding NC reads
//   biu_q_o/_stb_ack_o/_ack_o/_err_o/_adro_o/_tago_o  beat returned to the cache FSM
//   in_biubuffer_o, biubuffer_o   buffer hit for adr_i, assembled line
//   bus                           BIU request/response interface (master side)
//
// state     | meaning
// ST_IDLE   | no transfer; accepts READWAY or starts an NC read
// ST_NC     | NC reads outstanding; further strobes while below depth
// ST_FILL_REQ  | wrap burst requested at the critical word, waiting for acceptance
// ST_FILL_DATA | collecting beats into the line buffer

module riscv_icache_biu_fill
    import riscv_icache_biu_fill_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int PLEN           = 34,
    parameter int BLK_BITS       = 256,
    parameter int BEATS          = BLK_BITS / XLEN,
    parameter int INFLIGHT_DEPTH = 2,
    parameter int BIUTAG_SIZE    = 1,
    parameter int INFLIGHT_BITS  = $clog2(INFLIGHT_DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  biucmd_t                  biucmd_i,
    output logic                     biucmd_ack_o,
    input  logic                     biucmd_noncacheable_req_i,
    output logic                     biucmd_noncacheable_ack_o,
    input  logic [PLEN-1:0]          biucmd_adri_i,
    input  logic [PLEN-1:0]          adr_i,
    output logic [INFLIGHT_BITS-1:0] inflight_cnt_o,
    output logic [XLEN-1:0]          biu_q_o,
    output logic                     biu_stb_ack_o,
    output logic                     biu_ack_o,
    output logic                     biu_err_o,
    output logic [PLEN-1:0]          biu_adro_o,
    output logic [BIUTAG_SIZE-1:0]   biu_tago_o,
    output logic                     in_biubuffer_o,
    output logic [BLK_BITS-1:0]      biubuffer_o,
    riscv_icache_biu_fill_if.master  bus
);
    localparam int WORD_OFF  = $clog2(XLEN / 8);
    localparam int BEAT_BITS = $clog2(BEATS);
    localparam int LINE_OFF  = WORD_OFF + BEAT_BITS;
    localparam int TAG_BITS  = PLEN - LINE_OFF;
    localparam int NC_SLOTS  = 2 ** INFLIGHT_BITS;

    localparam logic [BEAT_BITS-1:0]     LAST_BEAT    = BEAT_BITS'(BEATS - 1);
    localparam logic [INFLIGHT_BITS-1:0] INFLIGHT_MAX = INFLIGHT_BITS'(INFLIGHT_DEPTH);
    localparam biu_size_t BUS_SIZE  = biu_size_t'(XLEN == 64 ? DWORD : WORD);
    localparam biu_type_t WRAP_TYPE = biu_type_t'(BEATS == 4 ? WRAP4 :
                                                  BEATS == 8 ? WRAP8 : WRAP16);

    typedef enum logic [1:0] {ST_IDLE, ST_NC, ST_FILL_REQ, ST_FILL_DATA} state_t;

    state_t                          state_q, state_d;
    logic [TAG_BITS-1:0]             tag_q;
    logic [BEAT_BITS-1:0]            beat_off_q, beat_cnt_q;
    logic [BEATS-1:0]                valid_q;
    logic [BEATS-1:0][XLEN-1:0]      buf_q;
    logic [INFLIGHT_BITS-1:0]        inflight_q, discard_q, push_idx;
    logic [PLEN-1:0]                 nc_adr_q [NC_SLOTS];

    logic            stb, fill_start, beat_wr, fill_abort, nc_push, nc_pop, kill;
    logic [PLEN-1:0] adri, nc_adr, beat_adr;
    biu_type_t       btype;

    assign nc_adr   = {biucmd_adri_i[PLEN-1:WORD_OFF], {WORD_OFF{1'b0}}};
    assign beat_adr = {tag_q, beat_off_q, {WORD_OFF{1'b0}}};
    // Responses are dropped on the flush cycle itself and while older reads drain.
    assign kill     = flush_i | (discard_q != '0);

    always_comb begin
        state_d    = state_q;
        stb        = 1'b0;
        adri       = '0;
        btype      = SINGLE;
        fill_start = 1'b0;
        beat_wr    = 1'b0;
        fill_abort = 1'b0;
        nc_pop     = 1'b0;
        biu_ack_o  = 1'b0;
        biu_err_o  = 1'b0;
        biu_adro_o = '0;
        biucmd_ack_o              = 1'b0;
        biucmd_noncacheable_ack_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (biucmd_i == BIUCMD_READWAY) begin
                    fill_start = 1'b1;
                    state_d    = ST_FILL_REQ;
                end else if (biucmd_noncacheable_req_i && !flush_i) begin
                    stb     = 1'b1;
                    adri    = nc_adr;
                    state_d = ST_NC;
                end
            end
            ST_NC: begin
                stb    = biucmd_noncacheable_req_i && !flush_i && (inflight_q < INFLIGHT_MAX);
                adri   = stb ? nc_adr : '0;
                nc_pop = bus.ack | bus.err;
                biu_ack_o  = bus.ack & ~kill;
                biu_err_o  = bus.err & ~kill;
                biucmd_noncacheable_ack_o = biu_ack_o;
                if (biu_ack_o || biu_err_o) biu_adro_o = nc_adr_q[0];
                if (inflight_q == '0 && !biucmd_noncacheable_req_i) state_d = ST_IDLE;
            end
            ST_FILL_REQ: begin
                stb   = 1'b1;
                adri  = beat_adr;
                btype = WRAP_TYPE;
                if (bus.stb_ack) state_d = ST_FILL_DATA;
            end
            ST_FILL_DATA: begin
                if (bus.err) begin
                    biu_err_o  = 1'b1;
                    biu_adro_o = beat_adr;
                    fill_abort = 1'b1;
                    state_d    = ST_IDLE;
                end else if (bus.ack) begin
                    biu_ack_o  = 1'b1;
                    biu_adro_o = beat_adr;
                    beat_wr    = 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        biucmd_ack_o = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign nc_push  = stb & bus.stb_ack & (state_q != ST_FILL_REQ);
    assign push_idx = inflight_q - INFLIGHT_BITS'(nc_pop);

    assign bus.stb   = stb;
    assign bus.adri  = adri;
    assign bus.btype = btype;
    assign bus.size  = stb ? BUS_SIZE : BYTE;
    assign bus.we    = 1'b0;

    assign biu_stb_ack_o  = stb & bus.stb_ack;
    assign biu_q_o        = biu_ack_o ? bus.q : '0;
    assign biu_tago_o     = biu_adro_o[1 +: BIUTAG_SIZE];
    assign inflight_cnt_o = inflight_q;
    assign biubuffer_o    = buf_q;
    assign in_biubuffer_o = (adr_i[PLEN-1:LINE_OFF] == tag_q) &
                            valid_q[adr_i[LINE_OFF-1:WORD_OFF]];

    logic unused_low_bits;
    assign unused_low_bits = ^{adr_i[WORD_OFF-1:0], biucmd_adri_i[WORD_OFF-1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tag_q      <= '0;
            beat_off_q <= '0;
            beat_cnt_q <= '0;
            valid_q    <= '0;
            buf_q      <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            nc_adr_q   <= '{default: '0};
        end else begin
            state_q <= state_d;

            if (fill_start) begin
                tag_q      <= biucmd_adri_i[PLEN-1:LINE_OFF];
                beat_off_q <= biucmd_adri_i[LINE_OFF-1:WORD_OFF];
                beat_cnt_q <= '0;
                valid_q    <= '0;
            end
            if (beat_wr) begin
                buf_q[beat_off_q]   <= bus.q;
                valid_q[beat_off_q] <= 1'b1;
                beat_off_q          <= beat_off_q + 1'b1;
                beat_cnt_q          <= beat_cnt_q + 1'b1;
            end
            if (fill_abort) valid_q <= '0;

            case ({nc_push, nc_pop})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase

            // Return addresses queue in request order; index 0 is the oldest.
            if (nc_pop) begin
                for (int i = 0; i < NC_SLOTS - 1; i++) nc_adr_q[i] <= nc_adr_q[i+1];
            end
            if (nc_push) nc_adr_q[push_idx] <= adri;

            if (state_q == ST_NC && flush_i)
                discard_q <= inflight_q - INFLIGHT_BITS'(nc_pop);
            else if (discard_q != '0 && nc_pop)
                discard_q <= discard_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_icache_biu_fill.sv
module tb_riscv_icache_biu_fill;
    import riscv_icache_biu_fill_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    biucmd_t     biucmd_i = BIUCMD_NOP;
    logic        biucmd_ack_o;
    logic        nc_req = 1'b0;
    logic        nc_ack;
    logic [33:0] biucmd_adri_i = '0;
    logic [33:0] adr_i = '0;
    logic [1:0]  inflight_cnt_o;
    logic [31:0] biu_q_o;
    logic        biu_stb_ack_o, biu_ack_o, biu_err_o;
    logic [33:0] biu_adro_o;
    logic [0:0]  biu_tago_o;
    logic        in_biubuffer_o;
    logic [255:0] biubuffer_o;

    int vectors = 0;
    int miscompares = 0;

    riscv_icache_biu_fill_if #(.XLEN(32), .PLEN(34)) bus ();

    riscv_icache_biu_fill dut (
        .clk_i                     (clk_i),
        .rst_ni                    (rst_ni),
        .flush_i                   (flush_i),
        .biucmd_i                  (biucmd_i),
        .biucmd_ack_o              (biucmd_ack_o),
        .biucmd_noncacheable_req_i (nc_req),
        .biucmd_noncacheable_ack_o (nc_ack),
        .biucmd_adri_i             (biucmd_adri_i),
        .adr_i                     (adr_i),
        .inflight_cnt_o            (inflight_cnt_o),
        .biu_q_o                   (biu_q_o),
        .biu_stb_ack_o             (biu_stb_ack_o),
        .biu_ack_o                 (biu_ack_o),
        .biu_err_o                 (biu_err_o),
        .biu_adro_o                (biu_adro_o),
        .biu_tago_o                (biu_tago_o),
        .in_biubuffer_o            (in_biubuffer_o),
        .biubuffer_o               (biubuffer_o),
        .bus                       (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    initial begin
        bus.stb_ack = 1'b0;
        bus.ack     = 1'b0;
        bus.err     = 1'b0;
        bus.q       = '0;

        // ---------------- reset values ----------------
        next_cycle();
        #1;
        chk("rst_stb", bus.stb, 0);
        chk("rst_size", bus.size, 0);
        chk("rst_type", bus.btype, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_cmdack", biucmd_ack_o, 0);
        chk("rst_inflight", inflight_cnt_o, 0);
        chk("rst_inbuf", in_biubuffer_o, 0);
        chk("rst_buf_lo", biubuffer_o[63:0], 0);
        chk("rst_adro", biu_adro_o, 0);
        next_cycle();
        rst_ni = 1'b1;

        // ---------------- line fill at 0x104, no stalls ----------------
        next_cycle();
        biucmd_i = BIUCMD_READWAY;
        biucmd_adri_i = 34'h104;
        #1 chk("rw_idle_stb", bus.stb, 0);
        next_cycle();
        biucmd_i = BIUCMD_NOP;
        #1;
        chk("fill_stb", bus.stb, 1);
        chk("fill_adri", bus.adri, 34'h104);
        chk("fill_type", bus.btype, 4);
        chk("fill_size", bus.size, 2);
        chk("fill_stbackout_pre", biu_stb_ack_o, 0);
        bus.stb_ack = 1'b1;
        #1 chk("fill_stbackout", biu_stb_ack_o, 1);
        for (int i = 0; i < 8; i++) begin
            logic [33:0] a;
            next_cycle();
            a = 34'h100 + 34'(((i + 1) % 8) * 4);
            bus.stb_ack = 1'b0;
            bus.ack = 1'b1;
            bus.q = 32'hA000_0000 + 32'(a);
            #1;
            chk("beat_ack", biu_ack_o, 1);
            chk("beat_adro", biu_adro_o, a);
            chk("beat_q", biu_q_o, 32'hA000_0000 + 32'(a));
            chk("beat_cmdack", biucmd_ack_o, (i == 7) ? 1 : 0);
            chk("beat_stb", bus.stb, 0);
        end
        next_cycle();
        bus.ack = 1'b0;
        adr_i = 34'h10C;
        #1;
        chk("post_cmdack", biucmd_ack_o, 0);
        chk("post_ack", biu_ack_o, 0);
        for (int k = 0; k < 8; k++)
            chk("line_word", biubuffer_o[k*32 +: 32], 32'hA000_0100 + 32'(k * 4));
        chk("hit_10c", in_biubuffer_o, 1);
        adr_i = 34'h20C;
        #1 chk("miss_20c", in_biubuffer_o, 0);

        // ---------------- fill 0x300 with lookup of 0x308 and one stall ----------------
        next_cycle();
        biucmd_i = BIUCMD_READWAY;
        biucmd_adri_i = 34'h300;
        adr_i = 34'h308;
        next_cycle();
        biucmd_i = BIUCMD_NOP;
        bus.stb_ack = 1'b1;
        #1;
        chk("f300_adri", bus.adri, 34'h300);
        chk("f300_inbuf_req", in_biubuffer_o, 0);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            bus.stb_ack = 1'b0;
            if (i == 4) begin
                bus.ack = 1'b0;
                #1 chk("f300_stall_ack", biu_ack_o, 0);
                next_cycle();
            end
            bus.ack = 1'b1;
            bus.q = 32'h5000_0000 + 32'(i);
            #1;
            chk("f300_adro", biu_adro_o, 34'h300 + 34'(i * 4));
            chk("f300_inbuf", in_biubuffer_o, (i >= 3) ? 1 : 0);
            chk("f300_cmdack", biucmd_ack_o, (i == 7) ? 1 : 0);
        end
        next_cycle();
        bus.ack = 1'b0;
        #1 chk("f300_hit_308", in_biubuffer_o, 1);
        adr_i = 34'h408;
        #1 chk("f300_miss_408", in_biubuffer_o, 0);

        // ---------------- error on third beat ----------------
        next_cycle();
        biucmd_i = BIUCMD_READWAY;
        biucmd_adri_i = 34'h140;
        adr_i = 34'h140;
        next_cycle();
        biucmd_i = BIUCMD_NOP;
        bus.stb_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            bus.stb_ack = 1'b0;
            bus.ack = 1'b1;
            bus.q = 32'hE000_0000 + 32'(i);
        end
        next_cycle();
        bus.ack = 1'b0;
        bus.err = 1'b1;
        #1;
        chk("err_out", biu_err_o, 1);
        chk("err_ack", biu_ack_o, 0);
        chk("err_cmdack", biucmd_ack_o, 0);
        next_cycle();
        bus.err = 1'b0;
        #1;
        chk("err_clear", biu_err_o, 0);
        chk("err_inbuf", in_biubuffer_o, 0);
        chk("err_stb", bus.stb, 0);

        // ---------------- two back-to-back NC reads ----------------
        nc_req = 1'b1;
        biucmd_adri_i = 34'h200;
        #1;
        chk("nc0_stb", bus.stb, 1);
        chk("nc0_adri", bus.adri, 34'h200);
        chk("nc0_type", bus.btype, 0);
        chk("nc0_inflight", inflight_cnt_o, 0);
        bus.stb_ack = 1'b1;
        next_cycle();
        biucmd_adri_i = 34'h204;
        #1;
        chk("nc1_inflight", inflight_cnt_o, 1);
        chk("nc1_stb", bus.stb, 1);
        chk("nc1_adri", bus.adri, 34'h204);
        next_cycle();
        bus.stb_ack = 1'b0;
        biucmd_adri_i = 34'h208;
        #1;
        chk("nc2_inflight", inflight_cnt_o, 2);
        chk("nc2_blocked", bus.stb, 0);
        next_cycle();
        nc_req = 1'b0;
        bus.ack = 1'b1;
        bus.q = 32'h1111_1111;
        #1;
        chk("ncr0_ack", nc_ack, 1);
        chk("ncr0_biuack", biu_ack_o, 1);
        chk("ncr0_q", biu_q_o, 32'h1111_1111);
        chk("ncr0_adro", biu_adro_o, 34'h200);
        chk("ncr0_tag", biu_tago_o, 0);
        next_cycle();
        bus.q = 32'h2222_2222;
        #1;
        chk("ncr1_inflight", inflight_cnt_o, 1);
        chk("ncr1_ack", nc_ack, 1);
        chk("ncr1_adro", biu_adro_o, 34'h204);
        next_cycle();
        bus.ack = 1'b0;
        #1;
        chk("ncr2_inflight", inflight_cnt_o, 0);
        chk("ncr2_ack", nc_ack, 0);

        // ---------------- flush with two reads in flight ----------------
        next_cycle();
        nc_req = 1'b1;
        biucmd_adri_i = 34'h20E;
        bus.stb_ack = 1'b1;
        #1 chk("fl0_adri_aligned", bus.adri, 34'h20C);
        next_cycle();
        biucmd_adri_i = 34'h210;
        next_cycle();
        bus.stb_ack = 1'b0;
        flush_i = 1'b1;
        #1;
        chk("fl_inflight", inflight_cnt_o, 2);
        chk("fl_no_stb", bus.stb, 0);
        next_cycle();
        flush_i = 1'b0;
        nc_req = 1'b0;
        bus.ack = 1'b1;
        bus.q = 32'h3333_3333;
        #1;
        chk("fl_rsp0_ack", nc_ack, 0);
        chk("fl_rsp0_biuack", biu_ack_o, 0);
        next_cycle();
        #1;
        chk("fl_rsp1_inflight", inflight_cnt_o, 1);
        chk("fl_rsp1_ack", nc_ack, 0);
        next_cycle();
        bus.ack = 1'b0;
        #1 chk("fl_done_inflight", inflight_cnt_o, 0);
        next_cycle();
        nc_req = 1'b1;
        biucmd_adri_i = 34'h220;
        bus.stb_ack = 1'b1;
        #1 chk("fl_idle_stb", bus.stb, 1);
        next_cycle();
        nc_req = 1'b0;
        bus.stb_ack = 1'b0;
        bus.ack = 1'b1;
        bus.q = 32'h4444_4444;
        #1;
        chk("fl_after_ack", nc_ack, 1);
        chk("fl_after_adro", biu_adro_o, 34'h220);
        next_cycle();
        bus.ack = 1'b0;

        // ---------------- reset mid-burst ----------------
        next_cycle();
        biucmd_i = BIUCMD_READWAY;
        biucmd_adri_i = 34'h180;
        adr_i = 34'h180;
        next_cycle();
        biucmd_i = BIUCMD_NOP;
        bus.stb_ack = 1'b1;
        next_cycle();
        bus.stb_ack = 1'b0;
        bus.ack = 1'b1;
        bus.q = 32'h7777_7777;
        next_cycle();
        #1 chk("mid_inbuf_pre", in_biubuffer_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("mr_ack", biu_ack_o, 0);
        chk("mr_q", biu_q_o, 0);
        chk("mr_stb", bus.stb, 0);
        chk("mr_cmdack", biucmd_ack_o, 0);
        chk("mr_inbuf", in_biubuffer_o, 0);
        chk("mr_buf", biubuffer_o[255:192], 0);
        chk("mr_adro", biu_adro_o, 0);
        bus.ack = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
        nc_req = 1'b1;
        biucmd_adri_i = 34'h240;
        #1 chk("mr_idle_stb", bus.stb, 1);
        nc_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
